// File: rtl/pipe_pkg.sv
// Shared types and stage-boundary widths for the elastic pipeline register stages.
package pipe_pkg;

  localparam int unsigned PIPE_OCC_W = 2;

  typedef logic [PIPE_OCC_W-1:0] pipe_state_t;

  localparam pipe_state_t PS_EMPTY = 2'd0;
  localparam pipe_state_t PS_BUSY  = 2'd1;
  localparam pipe_state_t PS_FULL  = 2'd2;

  // Payload widths for each processor stage boundary
  localparam int unsigned IF_ID_DATA_W  = 16;
  localparam int unsigned IF_ID_CTRL_W  = 12;
  localparam int unsigned ID_EX_DATA_W  = 48;
  localparam int unsigned ID_EX_CTRL_W  = 12;
  localparam int unsigned EX_MEM_DATA_W = 32;
  localparam int unsigned EX_MEM_CTRL_W = 6;
  localparam int unsigned MEM_WB_DATA_W = 32;
  localparam int unsigned MEM_WB_CTRL_W = 3;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+data+ctrl holding register; clear wins over load and zeroes the payload.
module pipe_entry_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, stall and flush.
// Optional statistics counters are built when ELASTIC_PIPE_STATS_EN is defined.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = IF_ID_DATA_W,
  parameter int unsigned CTRL_W = IF_ID_CTRL_W,
  parameter int unsigned STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [PIPE_OCC_W-1:0] occupancy
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_cnt,
  output logic [STAT_W-1:0]     flush_cnt,
  output logic [STAT_W-1:0]     xfer_cnt
`endif
);

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  pipe_state_t state, state_nxt;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic              in_fire, out_fire;

  // Handshake depends only on held state, stall and flush, never on out_ready
  assign in_ready  = !skid_valid && !stall;
  assign out_valid = main_valid && !stall && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = PIPE_OCC_W'(state);

  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PS_EMPTY;
    else     state <= state_nxt;
  end

  // Next state and entry-register controls; flush overrides the handshake
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_nxt = PS_EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state_nxt = PS_BUSY;
            main_load = 1'b1;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = PS_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_nxt = PS_EMPTY;
            main_clr  = 1'b1;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_nxt      = PS_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_nxt = PS_EMPTY;
          main_clr  = 1'b1;
          skid_clr  = 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clr),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .valid  (skid_valid),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );

`ifdef ELASTIC_PIPE_STATS_EN
  // Saturating event counters; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (stall && (state != PS_EMPTY) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STAT_W'(1);
      if (flush && (state != PS_EMPTY) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + STAT_W'(1);
      if (out_fire && (xfer_cnt != '1))
        xfer_cnt <= xfer_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Scoreboard bench for elastic_pipe_stage; stats checks run when ELASTIC_PIPE_STATS_EN is defined.
module tb_elastic_pipe_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned STAT_W = 16;
  localparam int unsigned ENT_W  = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef ELASTIC_PIPE_STATS_EN
  logic [STAT_W-1:0] stall_cnt, flush_cnt, xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [ENT_W-1:0] sb[$];

  elastic_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAT_W(STAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef ELASTIC_PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  // Inputs are set at the falling edge; outputs are checked just before the rising edge
  task automatic tick();
    logic             exp_ir, exp_ov;
    logic [ENT_W-1:0] head;
    #4;
    exp_ir = (sb.size() < 2) && !stall;
    exp_ov = (sb.size() > 0) && !stall && !flush;
    head   = (sb.size() > 0) ? sb[0] : '0;
    chk("in_ready",  32'(in_ready),  32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("occupancy", 32'(occupancy), sb.size());
    chk("out_data",  32'(out_data),  32'(head[ENT_W-1:CTRL_W]));
    chk("out_ctrl",  32'(out_ctrl),  32'(head[CTRL_W-1:0]));
    if (flush) begin
      sb.delete();
    end else begin
      if (exp_ov && out_ready) void'(sb.pop_front());
      if (in_valid && exp_ir) sb.push_back({in_data, in_ctrl});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Latency 1, then one entry per cycle
    drive(1'b1, 16'h1234, 12'h00F, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h2000 + 16'(i), 12'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();

    // Fill skid, then drain in order
    drive(1'b1, 16'h0001, 12'h001, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0002, 12'h002, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00FF, 12'h0FF, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // Stall while FULL holds everything
    drive(1'b1, 16'h0001, 12'h001, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0002, 12'h002, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0BAD, 12'hBAD, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();

    // Flush from FULL and from BUSY; the concurrent input is dropped
    drive(1'b1, 16'h0004, 12'h004, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0003, 12'h003, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0006, 12'h006, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0005, 12'h005, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();

    // Random traffic including stall, flush and dropped in_valid
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      tick();
    end

    // Asynchronous reset while FULL
    drive(1'b1, 16'h00A1, 12'h0A1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00A2, 12'h0A2, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h00B1, 12'h0B1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();

`ifdef ELASTIC_PIPE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h3000 + 16'(i), 12'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00C1, 12'h0C1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); tick();
    chk("xfer_cnt",  32'(xfer_cnt),  32'd5);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
    chk("stall_cnt", 32'(stall_cnt), 32'd2);
    for (int i = 0; i < (1 << STAT_W) + 4; i++) begin
      drive(1'b1, 16'($urandom), 12'($urandom), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("xfer_cnt_sat", 32'(xfer_cnt), 32'(16'hFFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
